// File: rtl/l1_sched_pkg.sv
// Shared types and constants for the L1 host scheduler.
package l1_sched_pkg;

   localparam int unsigned DefNumHosts       = 2;
   localparam int unsigned DefMaxOutstanding = 2;
   localparam int unsigned DefWdogCycles     = 64;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_e;

   // Counter must hold 0..max_out inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/l1_rr_pick.sv
// Rotate-priority encoder: first eligible host scanning upward from rr_ptr, wrapping.
module l1_rr_pick #(
   parameter int unsigned NumHosts = 2,
   parameter int unsigned PtrW     = 1
) (
   input  logic [NumHosts-1:0] eligible,
   input  logic [PtrW-1:0]     rr_ptr,
   output logic [NumHosts-1:0] winner_oh,
   output logic [PtrW-1:0]     winner_idx,
   output logic                any_valid
);

   always_comb begin : pick
      int unsigned pos;
      winner_oh  = '0;
      winner_idx = '0;
      any_valid  = 1'b0;
      pos        = 0;
      for (int unsigned k = 0; k < NumHosts; k++) begin
         pos = int'(rr_ptr) + k;
         if (pos >= NumHosts) pos = pos - NumHosts;
         for (int unsigned h = 0; h < NumHosts; h++) begin
            if (!any_valid && eligible[h] && (h == pos)) begin
               any_valid    = 1'b1;
               winner_oh[h] = 1'b1;
               winner_idx   = PtrW'(h);
            end
         end
      end
   end

endmodule

// File: rtl/l1_host_scheduler.sv
// Round-robin grant of the shared L1 request network with per-host outstanding limits and bus lock.
// Optional starvation watchdog compiled in with L1_SCHED_WDOG_EN.
//
// state    | meaning
// UNLOCKED | any eligible host may be granted
// LOCKED   | only lock_owner may be granted
module l1_host_scheduler
   import l1_sched_pkg::*;
#(
   parameter int unsigned NumHosts       = DefNumHosts,
   parameter int unsigned MaxOutstanding = DefMaxOutstanding,
   parameter int unsigned WdogCycles     = DefWdogCycles
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NumHosts-1:0] host_req_valid_i,
   input  logic [NumHosts-1:0] host_lock_i,
   input  logic [NumHosts-1:0] network_ready_i,
   input  logic [NumHosts-1:0] host_resp_valid_i,
   output logic [NumHosts-1:0] host_gnt_o,
   output logic [NumHosts-1:0] resp_err_o,
   output logic [NumHosts-1:0] starve_o,
   output logic                idle_o
);

   localparam int unsigned CntW = cnt_width(MaxOutstanding);
   localparam int unsigned PtrW = (NumHosts > 1) ? $clog2(NumHosts) : 1;

   logic [PtrW-1:0]     rr_ptr;
   logic [CntW-1:0]     out_cnt [NumHosts];
   lock_state_e         lock_state, lock_state_nxt;
   logic [PtrW-1:0]     lock_owner, lock_owner_nxt;
   logic                lock_valid;
   logic [NumHosts-1:0] owner_oh;
   logic [NumHosts-1:0] eligible;
   logic [NumHosts-1:0] rr_oh;
   logic [PtrW-1:0]     rr_idx;
   logic                rr_any;
   logic [NumHosts-1:0] gnt_raw;
   logic [PtrW-1:0]     gnt_idx;
   logic                any_gnt;

   assign lock_valid = (lock_state == LOCKED);

   always_comb begin
      eligible = '0;
      owner_oh = '0;
      for (int unsigned h = 0; h < NumHosts; h++) begin
         owner_oh[h] = (lock_owner == PtrW'(h));
         eligible[h] = host_req_valid_i[h] & network_ready_i[h]
                     & (out_cnt[h] < CntW'(MaxOutstanding))
                     & (!lock_valid | owner_oh[h]);
      end
   end

   l1_rr_pick #(
      .NumHosts (NumHosts),
      .PtrW     (PtrW)
   ) u_rr_pick (
      .eligible   (eligible),
      .rr_ptr     (rr_ptr),
      .winner_oh  (rr_oh),
      .winner_idx (rr_idx),
      .any_valid  (rr_any)
   );

`ifdef L1_SCHED_WDOG_EN
   localparam int unsigned WdW = $clog2(WdogCycles + 1);

   logic [WdW-1:0]      wait_cnt [NumHosts];
   logic [NumHosts-1:0] starving;
   logic [NumHosts-1:0] st_oh;
   logic [PtrW-1:0]     st_idx;
   logic                st_any;

   // Starving hosts still have to be eligible, so lock and limits are honoured.
   always_comb begin
      starving = '0;
      st_oh    = '0;
      st_idx   = '0;
      st_any   = 1'b0;
      for (int unsigned h = 0; h < NumHosts; h++) begin
         starving[h] = (wait_cnt[h] == WdW'(WdogCycles));
         if (!st_any && starving[h] && eligible[h]) begin
            st_any   = 1'b1;
            st_oh[h] = 1'b1;
            st_idx   = PtrW'(h);
         end
      end
   end

   assign gnt_raw  = st_any ? st_oh  : rr_oh;
   assign gnt_idx  = st_any ? st_idx : rr_idx;
   assign starve_o = starving;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned h = 0; h < NumHosts; h++) wait_cnt[h] <= '0;
      end else begin
         for (int unsigned h = 0; h < NumHosts; h++) begin
            if (!host_req_valid_i[h] || host_gnt_o[h]) wait_cnt[h] <= '0;
            else if (!starving[h]) wait_cnt[h] <= wait_cnt[h] + WdW'(1);
         end
      end
   end
`else
   assign gnt_raw  = rr_oh;
   assign gnt_idx  = rr_idx;
   assign starve_o = '0;
`endif

   // Grant is forced low while reset is asserted, independent of the clock.
   assign host_gnt_o = rst_i ? '0 : gnt_raw;
   assign any_gnt    = |host_gnt_o;

   always_comb begin
      resp_err_o = '0;
      for (int unsigned h = 0; h < NumHosts; h++)
         resp_err_o[h] = !rst_i & host_resp_valid_i[h] & (out_cnt[h] == '0);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr <= '0;
         for (int unsigned h = 0; h < NumHosts; h++) out_cnt[h] <= '0;
      end else begin
         if (any_gnt)
            rr_ptr <= (gnt_idx == PtrW'(NumHosts - 1)) ? '0 : gnt_idx + PtrW'(1);
         for (int unsigned h = 0; h < NumHosts; h++) begin
            if (host_gnt_o[h] && !host_resp_valid_i[h])
               out_cnt[h] <= out_cnt[h] + CntW'(1);
            else if (!host_gnt_o[h] && host_resp_valid_i[h] && out_cnt[h] != '0)
               out_cnt[h] <= out_cnt[h] - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_state <= UNLOCKED;
         lock_owner <= '0;
      end else begin
         lock_state <= lock_state_nxt;
         lock_owner <= lock_owner_nxt;
      end
   end

   always_comb begin
      lock_state_nxt = lock_state;
      lock_owner_nxt = lock_owner;
      case (lock_state)
         UNLOCKED: begin
            if (|(host_gnt_o & host_lock_i)) begin
               lock_state_nxt = LOCKED;
               lock_owner_nxt = gnt_idx;
            end
         end
         LOCKED: begin
            // Owner either finishes with an unlocked grant or abandons the sequence.
            if (|(owner_oh & host_gnt_o & ~host_lock_i) ||
                |(owner_oh & ~host_req_valid_i & ~host_lock_i))
               lock_state_nxt = UNLOCKED;
         end
         default: lock_state_nxt = UNLOCKED;
      endcase
   end

   always_comb begin
      idle_o = !lock_valid;
      for (int unsigned h = 0; h < NumHosts; h++)
         if (out_cnt[h] != '0) idle_o = 1'b0;
   end

endmodule

// File: tb/tb_l1_host_scheduler.sv
// Self-checking bench for l1_host_scheduler: vector table, directed corner sequences, randomized model check.
module tb_l1_host_scheduler;

   localparam int N     = 2;
   localparam int MAXO  = 2;
   localparam int WDOG  = 4;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [N-1:0] req, lock, ready, resp;
   logic [N-1:0] gnt, err, starve;
   logic         idle;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   l1_host_scheduler #(
      .NumHosts       (N),
      .MaxOutstanding (MAXO),
      .WdogCycles     (WDOG)
   ) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .host_req_valid_i  (req),
      .host_lock_i       (lock),
      .network_ready_i   (ready),
      .host_resp_valid_i (resp),
      .host_gnt_o        (gnt),
      .resp_err_o        (err),
      .starve_o          (starve),
      .idle_o            (idle)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [N-1:0] rq, input logic [N-1:0] lk,
                        input logic [N-1:0] rd, input logic [N-1:0] rs);
      req = rq; lock = lk; ready = rd; resp = rs;
   endtask

   typedef struct {
      logic [N-1:0] req, lock, ready, resp, gnt, err;
      logic         idle;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [N-1:0] rq, lk, rd, rs, g, e, input logic i);
      vec_t v;
      v.req = rq; v.lock = lk; v.ready = rd; v.resp = rs; v.gnt = g; v.err = e; v.idle = i;
      return v;
   endfunction

   // Reference model state, updated once per clock from the observable rules.
   int m_cnt[N];
   int m_wait[N];
   int m_rr;
   bit m_lock;
   int m_owner;

   task automatic model_reset();
      for (int h = 0; h < N; h++) begin m_cnt[h] = 0; m_wait[h] = 0; end
      m_rr = 0; m_lock = 0; m_owner = 0;
   endtask

   task automatic model_step(input logic [N-1:0] rq, lk, rd, rs,
                             output logic [N-1:0] eg, ee, es, output logic ei);
      bit el[N];
      int w;
      w = -1;
      for (int h = 0; h < N; h++)
         el[h] = rq[h] && rd[h] && (m_cnt[h] < MAXO) && (!m_lock || m_owner == h);
`ifdef L1_SCHED_WDOG_EN
      for (int h = 0; h < N; h++)
         if (w < 0 && el[h] && m_wait[h] == WDOG) w = h;
`endif
      for (int k = 0; k < N; k++)
         if (w < 0 && el[(m_rr + k) % N]) w = (m_rr + k) % N;
      eg = '0; ee = '0; es = '0;
      if (w >= 0) eg[w] = 1'b1;
      ei = !m_lock;
      for (int h = 0; h < N; h++) begin
         ee[h] = rs[h] && (m_cnt[h] == 0);
         if (m_cnt[h] != 0) ei = 1'b0;
`ifdef L1_SCHED_WDOG_EN
         es[h] = (m_wait[h] == WDOG);
`endif
      end
      for (int h = 0; h < N; h++) begin
         if (w == h && !rs[h]) m_cnt[h]++;
         else if (w != h && rs[h] && m_cnt[h] > 0) m_cnt[h]--;
         if (!rq[h] || w == h) m_wait[h] = 0;
         else if (m_wait[h] < WDOG) m_wait[h]++;
      end
      if (!m_lock) begin
         if (w >= 0 && lk[w]) begin m_lock = 1; m_owner = w; end
      end else if ((w == m_owner && !lk[m_owner]) || (!rq[m_owner] && !lk[m_owner])) begin
         m_lock = 0;
      end
      if (w >= 0) m_rr = (w + 1) % N;
   endtask

   initial begin
      logic [N-1:0] eg, ee, es, rq, lk, rd, rs;
      logic ei;

      //            req    lock   ready  resp   gnt    err    idle
      tbl.push_back(mk(2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 1));
      tbl.push_back(mk(2'b11, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1));
      tbl.push_back(mk(2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b01, 1)); // stray response
      tbl.push_back(mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1));
      tbl.push_back(mk(2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 1));
      tbl.push_back(mk(2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 0));
      tbl.push_back(mk(2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0)); // limit reached
      tbl.push_back(mk(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0)); // no bypass
      tbl.push_back(mk(2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 0));
      tbl.push_back(mk(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1));
      tbl.push_back(mk(2'b10, 2'b10, 2'b11, 2'b00, 2'b10, 2'b00, 1)); // H1 takes lock
      tbl.push_back(mk(2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00, 0));
      tbl.push_back(mk(2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00, 0));
      tbl.push_back(mk(2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 0)); // unlocking grant
      tbl.push_back(mk(2'b11, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1));
      tbl.push_back(mk(2'b01, 2'b01, 2'b11, 2'b00, 2'b01, 2'b00, 1)); // H0 takes lock
      tbl.push_back(mk(2'b10, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 0)); // owner drops
      tbl.push_back(mk(2'b10, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 1));
      tbl.push_back(mk(2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1));

      rst_i = 1'b1;
      drive(2'b11, 2'b00, 2'b11, 2'b11);
      #2;
      chk("reset_gnt", gnt, 2'b00);
      chk("reset_err", err, 2'b00);
      chk("reset_idle", idle, 1'b1);
      chk("reset_starve", starve, 2'b00);
      @(negedge clk_i);
      rst_i = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].req, tbl[i].lock, tbl[i].ready, tbl[i].resp);
         #1;
         chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
         chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
         chk($sformatf("tbl%0d_idle", i), idle, tbl[i].idle);
         @(negedge clk_i);
      end

      // Reset in the middle of a burst with H0 at its limit.
      drive(2'b01, 2'b00, 2'b01, 2'b00); #1; chk("rst_seq_g0", gnt, 2'b01); @(negedge clk_i);
      #1; chk("rst_seq_g1", gnt, 2'b01); @(negedge clk_i);
      #1; chk("rst_seq_full", gnt, 2'b00);
      #2; rst_i = 1'b1; #1;
      chk("rst_async_gnt", gnt, 2'b00);
      chk("rst_async_idle", idle, 1'b1);
      @(negedge clk_i);
      rst_i = 1'b0;
      drive(2'b00, 2'b00, 2'b11, 2'b01); #1; chk("rst_late_resp_err", err, 2'b01); @(negedge clk_i);
      drive(2'b11, 2'b00, 2'b11, 2'b00); #1; chk("rst_first_gnt", gnt, 2'b01); @(negedge clk_i);
      drive(2'b00, 2'b00, 2'b11, 2'b01); #1; chk("rst_resp_ok", err, 2'b00); @(negedge clk_i);
      drive(2'b00, 2'b00, 2'b11, 2'b00); #1; chk("rst_idle_back", idle, 1'b1); @(negedge clk_i);

`ifdef L1_SCHED_WDOG_EN
      rst_i = 1'b1; #1; @(negedge clk_i); rst_i = 1'b0;
      for (int c = 0; c < WDOG; c++) begin
         drive(2'b10, 2'b00, 2'b00, 2'b00); #1;
         chk($sformatf("wdog_wait%0d", c), starve, 2'b00);
         @(negedge clk_i);
      end
      drive(2'b11, 2'b00, 2'b11, 2'b00); #1;
      chk("wdog_starve", starve, 2'b10);
      chk("wdog_override", gnt, 2'b10);
      @(negedge clk_i);
      drive(2'b00, 2'b00, 2'b11, 2'b00); #1;
      chk("wdog_cleared", starve, 2'b00);
      @(negedge clk_i);
`endif

      rst_i = 1'b1; #1; @(negedge clk_i); rst_i = 1'b0;
      model_reset();
      for (int c = 0; c < 600; c++) begin
         for (int h = 0; h < N; h++) begin
            rq[h] = ($urandom_range(0, 3) != 0);
            lk[h] = ($urandom_range(0, 3) == 0);
            rd[h] = ($urandom_range(0, 3) != 0);
            rs[h] = (m_cnt[h] > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
         end
         drive(rq, lk, rd, rs);
         model_step(rq, lk, rd, rs, eg, ee, es, ei);
         #1;
         chk($sformatf("rnd%0d_gnt", c), gnt, eg);
         chk($sformatf("rnd%0d_err", c), err, ee);
         chk($sformatf("rnd%0d_idle", c), idle, ei);
         chk($sformatf("rnd%0d_starve", c), starve, es);
         @(negedge clk_i);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
